// File: rtl/rs_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler_pkg
//  Description : Shared types and sizing for the reservation-station issue
//                scheduler. The entry view holds the per-entry status bits the
//                scheduler consumes. The issue packet describes the contents
//                of the one-deep issue slot.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_issue_scheduler_pkg;

   // Core sizing: the reservation-station depth lives next to the ROB depth.
   localparam int ROB_SIZE = 8;
   localparam int NUM_RS   = 3;
   localparam int IDX_W    = $clog2(NUM_RS);

   // Status of one reservation-station entry as seen by the scheduler.
   typedef struct packed {
      logic busy;
      logic ready;
      logic is_mem;
   } rs_entry_t;

   // Contents of the issue slot handed to EX.
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] issue_idx;
      logic             issue_is_mem;
   } RS_ISSUE_PACKET;

endpackage : rs_issue_scheduler_pkg
`default_nettype wire

// File: rtl/rs_issue_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler_if
//  Description : Bundle between the RS entry array / EX stage and the issue
//                scheduler.
//                master : the scheduler (drives the issue slot and flags)
//                slave  : the surrounding pipeline (drives entry status,
//                         dispatch alloc, releases, flush, EX/MEM handshakes)
//  Ports       : entry_busy/ready/is_mem, alloc_valid/idx, entry_free, flush,
//                ex_ready, mem_done  -> scheduler
//                issue_valid/idx/is_mem, issued_mask, mem_inflight, rr_ptr
//                                    <- scheduler
//  Revision    : 1.0  initial release
// ============================================================================
interface rs_issue_scheduler_if #(
   parameter int NUM_RS = rs_issue_scheduler_pkg::NUM_RS,
   parameter int IDX_W  = $clog2(NUM_RS)
) ();
   logic [NUM_RS-1:0] entry_busy;
   logic [NUM_RS-1:0] entry_ready;
   logic [NUM_RS-1:0] entry_is_mem;
   logic              alloc_valid;
   logic [IDX_W-1:0]  alloc_idx;
   logic [NUM_RS-1:0] entry_free;
   logic              flush;
   logic              ex_ready;
   logic              mem_done;

   logic              issue_valid;
   logic [IDX_W-1:0]  issue_idx;
   logic              issue_is_mem;
   logic [NUM_RS-1:0] issued_mask;
   logic              mem_inflight;
   logic [IDX_W-1:0]  rr_ptr;

   modport master (
      input  entry_busy, entry_ready, entry_is_mem, alloc_valid, alloc_idx,
             entry_free, flush, ex_ready, mem_done,
      output issue_valid, issue_idx, issue_is_mem, issued_mask, mem_inflight,
             rr_ptr
   );

   modport slave (
      output entry_busy, entry_ready, entry_is_mem, alloc_valid, alloc_idx,
             entry_free, flush, ex_ready, mem_done,
      input  issue_valid, issue_idx, issue_is_mem, issued_mask, mem_inflight,
             rr_ptr
   );
endinterface : rs_issue_scheduler_if
`default_nettype wire

// File: rtl/rs_issue_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler_rr_arbiter
//  Description : Combinational round-robin arbiter. Requests are rotated so
//                that index ptr sits at position 0. The first set position is
//                found, and it is rotated back to an absolute entry index.
//  Ports       : req     - request vector
//                ptr     - highest-priority index (always < NUM_RS)
//                gnt     - one-hot grant
//                gnt_idx - granted index (equals ptr when nothing is granted)
//                any     - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rs_issue_scheduler_rr_arbiter #(
   parameter int NUM_RS = 3,
   parameter int IDX_W  = $clog2(NUM_RS)
) (
   input  wire logic [NUM_RS-1:0] req,
   input  wire logic [IDX_W-1:0]  ptr,
   output logic      [NUM_RS-1:0] gnt,
   output logic      [IDX_W-1:0]  gnt_idx,
   output logic                   any
);

   logic [NUM_RS-1:0] w_rot;
   logic [IDX_W-1:0]  w_first;

   // (base + offs) mod NUM_RS. Both operands are below NUM_RS, so a single
   // conditional subtract suffices, and non-power-of-two sizes stay exact.
   function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base,
                                               input int offs);
      int s;
      s = int'(base) + offs;
      if (s >= NUM_RS) s = s - NUM_RS;
      return IDX_W'(s);
   endfunction

   always_comb begin
      w_rot   = '0;
      w_first = '0;
      any     = 1'b0;
      gnt     = '0;
      for (int k = 0; k < NUM_RS; k++) begin
         w_rot[k] = req[f_wrap(ptr, k)];
      end
      // Descending scan so the lowest rotated position is the one that sticks.
      for (int k = NUM_RS - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            any     = 1'b1;
            w_first = IDX_W'(k);
         end
      end
      gnt_idx = f_wrap(ptr, int'(w_first));
      if (any) gnt[gnt_idx] = 1'b1;
   end

endmodule : rs_issue_scheduler_rr_arbiter
`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_scheduler
//  Description : Chooses one reservation-station entry per cycle for the
//                execute stage. It owns the per-entry issued flags, the
//                one-deep registered issue slot (valid/ready toward EX), the
//                round-robin pointer and the single memory-op-in-flight
//                interlock.
//  Ports       : clock   - rising-edge clock
//                reset_n - asynchronous active-low reset
//                bus     - rs_issue_scheduler_if.master (entry status in,
//                          issue slot and flags out)
//  Revision    : 1.0  initial release
// ============================================================================
module rs_issue_scheduler #(
   parameter int NUM_RS = rs_issue_scheduler_pkg::NUM_RS,
   parameter int IDX_W  = $clog2(NUM_RS)
) (
   input wire logic             clock,
   input wire logic             reset_n,
   rs_issue_scheduler_if.master bus
);
   import rs_issue_scheduler_pkg::*;

   logic              r_issue_valid;
   logic [IDX_W-1:0]  r_issue_idx;
   logic              r_issue_is_mem;
   logic [NUM_RS-1:0] r_issued_mask;
   logic              r_mem_inflight;
   logic [IDX_W-1:0]  r_rr_ptr;

   rs_entry_t         w_entry [NUM_RS];
   logic [NUM_RS-1:0] w_eligible;
   logic [NUM_RS-1:0] w_clr;
   logic [NUM_RS-1:0] w_gnt;
   logic [IDX_W-1:0]  w_sel_idx;
   logic              w_any;
   logic              w_mem_block;
   logic              w_fire;
   logic              w_load;
   logic [IDX_W-1:0]  w_rr_next;
   logic [NUM_RS-1:0] w_mask_next;

   // A memory op sitting in the slot blocks further memory ops as much as one
   // already in EX/MEM does.
   assign w_mem_block = r_mem_inflight | (r_issue_valid & r_issue_is_mem);

   for (genvar i = 0; i < NUM_RS; i++) begin : g_entry
      assign w_entry[i]    = '{busy:   bus.entry_busy[i],
                               ready:  bus.entry_ready[i],
                               is_mem: bus.entry_is_mem[i]};
      assign w_eligible[i] = w_entry[i].busy & w_entry[i].ready
                           & ~r_issued_mask[i]
                           & ~(w_entry[i].is_mem & w_mem_block);
      assign w_clr[i]      = bus.entry_free[i]
                           | (bus.alloc_valid & (bus.alloc_idx == IDX_W'(i)));
   end

   rs_issue_scheduler_rr_arbiter #(
      .NUM_RS (NUM_RS),
      .IDX_W  (IDX_W)
   ) u_rr_arbiter (
      .req     (w_eligible),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_idx (w_sel_idx),
      .any     (w_any)
   );

   assign w_fire    = r_issue_valid & bus.ex_ready;
   assign w_load    = (~r_issue_valid | w_fire) & w_any & ~bus.flush;
   assign w_rr_next = (w_sel_idx == IDX_W'(NUM_RS - 1)) ? '0
                                                        : w_sel_idx + IDX_W'(1);
   // Applying the clear after the set makes a release win over a same-cycle issue.
   assign w_mask_next = (r_issued_mask | (w_load ? w_gnt : '0)) & ~w_clr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_issue_valid  <= 1'b0;
         r_issue_idx    <= '0;
         r_issue_is_mem <= 1'b0;
         r_issued_mask  <= '0;
         r_mem_inflight <= 1'b0;
         r_rr_ptr       <= '0;
      end else if (bus.flush) begin
         r_issue_valid  <= 1'b0;
         r_issued_mask  <= '0;
         r_mem_inflight <= 1'b0;
      end else begin
         if (w_load) begin
            r_issue_valid  <= 1'b1;
            r_issue_idx    <= w_sel_idx;
            r_issue_is_mem <= bus.entry_is_mem[w_sel_idx];
            r_rr_ptr       <= w_rr_next;
         end else if (w_fire) begin
            r_issue_valid  <= 1'b0;
         end
         r_issued_mask <= w_mask_next;
         if (w_fire & r_issue_is_mem) begin
            r_mem_inflight <= 1'b1;
         end else if (bus.mem_done) begin
            r_mem_inflight <= 1'b0;
         end
      end
   end

   assign bus.issue_valid  = r_issue_valid;
   assign bus.issue_idx    = r_issue_idx;
   assign bus.issue_is_mem = r_issue_is_mem;
   assign bus.issued_mask  = r_issued_mask;
   assign bus.mem_inflight = r_mem_inflight;
   assign bus.rr_ptr       = r_rr_ptr;

endmodule : rs_issue_scheduler
`default_nettype wire

// File: tb/tb_rs_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_issue_scheduler
//  Description : Self-checking bench for rs_issue_scheduler. It runs directed
//                scenarios against hand-derived expectations, then a random
//                run against a behavioural model of the issue rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_issue_scheduler;

   localparam int N  = 3;
   localparam int IW = $clog2(N);
   localparam int SW = 3 + 2 * IW + N;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   // Behavioural model state
   bit         m_valid;
   int         m_idx;
   bit         m_is_mem;
   bit [N-1:0] m_mask;
   bit         m_mem;
   int         m_rr;

   rs_issue_scheduler_if #(.NUM_RS(N), .IDX_W(IW)) bus ();

   rs_issue_scheduler #(.NUM_RS(N), .IDX_W(IW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Observed state: {valid, idx, is_mem, mask, mem_inflight, rr_ptr}
   function automatic logic [SW-1:0] snap();
      return {bus.issue_valid, bus.issue_idx, bus.issue_is_mem,
              bus.issued_mask, bus.mem_inflight, bus.rr_ptr};
   endfunction

   function automatic logic [SW-1:0] pack(input bit v, input int idx,
                                          input bit im, input bit [N-1:0] mask,
                                          input bit mi, input int rr);
      return {v, IW'(idx), im, mask, mi, IW'(rr)};
   endfunction

   task automatic clear_inputs();
      bus.entry_busy   = '0;
      bus.entry_ready  = '0;
      bus.entry_is_mem = '0;
      bus.alloc_valid  = 1'b0;
      bus.alloc_idx    = '0;
      bus.entry_free   = '0;
      bus.flush        = 1'b0;
      bus.ex_ready     = 1'b0;
      bus.mem_done     = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Advance the model by one clock using the currently driven inputs.
   task automatic model_tick();
      bit         fire, any, blk;
      int         sel;
      bit [N-1:0] clr;
      fire = m_valid && bus.ex_ready;
      blk  = m_mem || (m_valid && m_is_mem);
      any  = 0;
      sel  = 0;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (!any && bus.entry_busy[i] && bus.entry_ready[i] && !m_mask[i]
             && !(bus.entry_is_mem[i] && blk)) begin
            any = 1;
            sel = i;
         end
      end
      if (bus.flush) begin
         m_valid = 0;
         m_mask  = '0;
         m_mem   = 0;
         return;
      end
      for (int i = 0; i < N; i++)
         clr[i] = bus.entry_free[i] || (bus.alloc_valid && int'(bus.alloc_idx) == i);
      if (fire && m_is_mem) m_mem = 1;
      else if (bus.mem_done) m_mem = 0;
      if ((!m_valid || fire) && any) begin
         m_valid     = 1;
         m_idx       = sel;
         m_is_mem    = bus.entry_is_mem[sel];
         m_mask[sel] = 1;
         m_rr        = (sel + 1) % N;
      end else if (fire) begin
         m_valid = 0;
      end
      m_mask = m_mask & ~clr;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      bus.entry_busy  = 3'b111;
      bus.entry_ready = 3'b111;
      bus.ex_ready    = 1'b1;
      cycle();
      checks++;
      if (snap() !== pack(0, 0, 0, 3'b000, 0, 0)) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=%b", snap(), pack(0, 0, 0, 3'b000, 0, 0));
      end
      clear_inputs();
      reset_n = 1'b1;
      cycle();
      checks++;
      if (snap() !== pack(0, 0, 0, 3'b000, 0, 0)) begin
         failures++;
         $display("FAIL reset_idle got=%b exp=%b", snap(), pack(0, 0, 0, 3'b000, 0, 0));
      end
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] exp [4];
      exp[0] = pack(1, 0, 0, 3'b001, 0, 1);
      exp[1] = pack(1, 1, 0, 3'b011, 0, 2);
      exp[2] = pack(1, 2, 0, 3'b111, 0, 0);
      exp[3] = pack(0, 2, 0, 3'b111, 0, 0);
      apply_reset();
      bus.entry_busy  = 3'b111;
      bus.entry_ready = 3'b111;
      bus.ex_ready    = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         checks++;
         if (snap() !== exp[c]) begin
            failures++;
            $display("FAIL b2b_cyc%0d got=%b exp=%b", c + 1, snap(), exp[c]);
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      bus.entry_busy  = 3'b010;
      bus.entry_ready = 3'b010;
      bus.ex_ready    = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         checks++;
         if (snap() !== pack(1, 1, 0, 3'b010, 0, 2)) begin
            failures++;
            $display("FAIL stall_hold%0d got=%b exp=%b", c + 1, snap(),
                     pack(1, 1, 0, 3'b010, 0, 2));
         end
      end
      bus.ex_ready = 1'b1;
      cycle();
      checks++;
      if (snap() !== pack(0, 1, 0, 3'b010, 0, 2)) begin
         failures++;
         $display("FAIL stall_fire got=%b exp=%b", snap(), pack(0, 1, 0, 3'b010, 0, 2));
      end
   endtask

   task automatic test_mem_serialize();
      logic [SW-1:0] exp [5];
      exp[0] = pack(1, 0, 1, 3'b001, 0, 1);
      exp[1] = pack(0, 0, 1, 3'b001, 1, 1);
      exp[2] = pack(0, 0, 1, 3'b001, 1, 1);
      exp[3] = pack(0, 0, 1, 3'b001, 0, 1);
      exp[4] = pack(1, 2, 1, 3'b101, 0, 0);
      apply_reset();
      bus.entry_busy   = 3'b101;
      bus.entry_ready  = 3'b101;
      bus.entry_is_mem = 3'b101;
      bus.ex_ready     = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bus.mem_done = (c == 3);
         cycle();
         checks++;
         if (snap() !== exp[c]) begin
            failures++;
            $display("FAIL mem_cyc%0d got=%b exp=%b", c + 1, snap(), exp[c]);
         end
      end
      bus.mem_done = 1'b0;
   endtask

   task automatic test_rr_wrap();
      logic [SW-1:0] exp [5];
      exp[0] = pack(1, 0, 0, 3'b001, 0, 1);
      exp[1] = pack(1, 1, 0, 3'b011, 0, 2);
      exp[2] = pack(0, 1, 0, 3'b000, 0, 2);
      exp[3] = pack(1, 2, 0, 3'b100, 0, 0);
      exp[4] = pack(1, 0, 0, 3'b101, 0, 1);
      apply_reset();
      bus.ex_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         bus.entry_busy  = (c < 2) ? 3'b011 : (c == 2) ? 3'b000 : 3'b101;
         bus.entry_ready = bus.entry_busy;
         bus.entry_free  = (c == 2) ? 3'b011 : 3'b000;
         cycle();
         checks++;
         if (snap() !== exp[c]) begin
            failures++;
            $display("FAIL rr_cyc%0d got=%b exp=%b", c + 1, snap(), exp[c]);
         end
      end
   endtask

   task automatic test_flush();
      apply_reset();
      bus.entry_busy   = 3'b011;
      bus.entry_ready  = 3'b011;
      bus.entry_is_mem = 3'b001;
      bus.ex_ready     = 1'b1;
      repeat (2) cycle();
      checks++;
      if (snap() !== pack(1, 1, 0, 3'b011, 1, 2)) begin
         failures++;
         $display("FAIL flush_pre got=%b exp=%b", snap(), pack(1, 1, 0, 3'b011, 1, 2));
      end
      bus.flush    = 1'b1;
      bus.ex_ready = 1'b0;
      cycle();
      bus.flush = 1'b0;
      checks++;
      if (snap() !== pack(0, 1, 0, 3'b000, 0, 2)) begin
         failures++;
         $display("FAIL flush_post got=%b exp=%b", snap(), pack(0, 1, 0, 3'b000, 0, 2));
      end
   endtask

   task automatic test_free_and_async_reset();
      apply_reset();
      bus.entry_busy  = 3'b010;
      bus.entry_ready = 3'b010;
      bus.entry_free  = 3'b010;
      bus.ex_ready    = 1'b0;
      cycle();
      bus.entry_free = 3'b000;
      checks++;
      if (snap() !== pack(1, 1, 0, 3'b000, 0, 2)) begin
         failures++;
         $display("FAIL free_clear got=%b exp=%b", snap(), pack(1, 1, 0, 3'b000, 0, 2));
      end
      cycle();
      checks++;
      if (snap() !== pack(1, 1, 0, 3'b000, 0, 2)) begin
         failures++;
         $display("FAIL free_stall got=%b exp=%b", snap(), pack(1, 1, 0, 3'b000, 0, 2));
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (snap() !== pack(0, 0, 0, 3'b000, 0, 0)) begin
         failures++;
         $display("FAIL async_reset got=%b exp=%b", snap(), pack(0, 0, 0, 3'b000, 0, 0));
      end
      cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      apply_reset();
      m_valid  = 0;
      m_idx    = 0;
      m_is_mem = 0;
      m_mask   = '0;
      m_mem    = 0;
      m_rr     = 0;
      for (int c = 0; c < 400; c++) begin
         bus.entry_busy   = N'($urandom());
         bus.entry_ready  = N'($urandom());
         bus.entry_is_mem = N'($urandom());
         bus.alloc_valid  = ($urandom_range(0, 3) == 0);
         bus.alloc_idx    = IW'($urandom_range(0, N - 1));
         bus.entry_free   = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
         bus.flush        = ($urandom_range(0, 15) == 0);
         bus.ex_ready     = ($urandom_range(0, 3) != 0);
         bus.mem_done     = ($urandom_range(0, 3) == 0);
         model_tick();
         cycle();
         checks++;
         if (snap() !== pack(m_valid, m_idx, m_is_mem, m_mask, m_mem, m_rr)) begin
            failures++;
            $display("FAIL random_cyc%0d got=%b exp=%b", c, snap(),
                     pack(m_valid, m_idx, m_is_mem, m_mask, m_mem, m_rr));
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_back_to_back();
      test_stall();
      test_mem_serialize();
      test_rr_wrap();
      test_flush();
      test_free_and_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rs_issue_scheduler
`default_nettype wire

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Selects which reservation-station entry issues to the execute stage each cycle. Entries are round-robin arbitrated among those that are busy, operand-ready and not yet issued. The block owns the per-entry "issued" flags, which stop re-issue while an entry waits for CDB completion. It holds a one-deep registered issue slot with a valid/ready handshake toward EX, enforces at most one memory op in flight, and sits between the RS entry array and the EX-stage input register.

Parameters:
NUM_RS, 3, number of RS entries arbitrated (≥2)
IDX_W, $clog2(NUM_RS), entry index width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
entry_busy  in  NUM_RS  entry holds a valid instruction
entry_ready  in  NUM_RS  both source operands ready
entry_is_mem  in  NUM_RS  entry is a load or store
alloc_valid  in  1  dispatch writes an entry this cycle
alloc_idx  in  IDX_W  entry being written
entry_free  in  NUM_RS  per-entry release pulse (CDB completion)
flush  in  1  branch-mispredict squash
ex_ready  in  1  EX accepts the issue slot this cycle
mem_done  in  1  memory unit finished its op
issue_valid  out  1  issue slot holds an instruction
issue_idx  out  IDX_W  entry index in the slot
issue_is_mem  out  1  slot op is a memory op
issued_mask  out  NUM_RS  per-entry issued flags
mem_inflight  out  1  a memory op is in EX/MEM
rr_ptr  out  IDX_W  next round-robin start index

Behaviour:
- reset_n low (async, any time): issue_valid=0, issue_idx=0, issue_is_mem=0, issued_mask=0, mem_inflight=0, rr_ptr=0. Any in-progress operation is dropped.
- eligible[i] = entry_busy[i] & entry_ready[i] & !issued_mask[i] & !(entry_is_mem[i] & (mem_inflight | (issue_valid & issue_is_mem))).
- Selection is combinational. Pick the first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_RS with wrap-around.
- fire = issue_valid & ex_ready. load = (!issue_valid | fire) & any eligible & !flush.
- On load: issue_valid←1, issue_idx←sel, issue_is_mem←entry_is_mem[sel], issued_mask[sel]←1, rr_ptr←(sel+1) mod NUM_RS.
- On fire without load: issue_valid←0.
- While issue_valid & !ex_ready: issue_idx and issue_is_mem are held stable. No other entry is loaded.
- Latency: an entry eligible in cycle t with the slot free or firing in t appears with issue_valid=1 at t+1. With ex_ready held high, one issue per cycle back-to-back.
- mem_inflight: set on fire & issue_is_mem; cleared on mem_done. Both cannot occur in the same cycle by construction. If they do, set wins.
- issued_mask[i] is cleared by entry_free[i], or by alloc_valid & alloc_idx==i. A clear beats a set to the same index in the same cycle.
- flush (synchronous, highest priority after reset): issue_valid←0, issued_mask←0, mem_inflight←0; rr_ptr unchanged; no load that cycle. ex_ready is ignored that cycle.
- Index-0 entries are not special; all indices are treated uniformly.
- If no entry is eligible and the slot is empty, nothing changes except flag clears.

Decomposition:
- Shared package holds:
  - RS entry typedef and the RS_ISSUE_PACKET typedef (issue_idx, issue_is_mem, valid).
  - NUM_RS, defined next to ROB_SIZE.
- One natural sub-module: rr_arbiter. It takes (req[NUM_RS], ptr) and returns (gnt one-hot, gnt_idx, any) by rotate, find-first, un-rotate. The parent owns the slot register, issued flags, rr_ptr and mem_inflight.

Test Plan:
- All three entries busy+ready, none mem, ex_ready=1 from t0 → issue_idx 0,1,2 on consecutive cycles; issued_mask 001→011→111; rr_ptr ends 0.
- Entry 1 ready, ex_ready=0 for 3 cycles then 1 → issue_valid=1 with issue_idx=1 held all 3 cycles; fires on cycle 4; issue_valid=0 next cycle.
- Entries 0 and 2 both mem+ready → entry 0 issues, mem_inflight=1, entry 2 blocked; mem_done pulse → entry 2 issues the following cycle.
- rr_ptr=2, entries 0 and 2 eligible → entry 2 selected; rr_ptr wraps to 0.
- flush while slot valid (idx 1), issued_mask=011, mem_inflight=1 → next cycle issue_valid=0, issued_mask=000, mem_inflight=0, rr_ptr unchanged.
- entry_free[1] in the same cycle entry 1 is loaded, and reset_n dropped asynchronously mid-stall → issued_mask[1]=0 after the clear; on reset, all outputs are 0 immediately, before the next clock edge.
